// File: rtl/piso_shift_register_if.sv
// piso_shift_register_if
// Handshake and serial-side signals of the PISO transmitter.
//   master : producer/consumer side (drives load_valid, parallel_in)
//   slave  : transmitter side (drives load_ready and all serial outputs)
// Parameter WIDTH must match the transmitter instance it is bound to.
interface piso_shift_register_if #(
  parameter int WIDTH = 8
);
  logic             load_valid;
  logic [WIDTH-1:0] parallel_in;
  logic             load_ready;
  logic             serial_out;
  logic             serial_valid;
  logic             frame_start;
  logic             frame_end;
  logic             busy;

  modport master (
    output load_valid, parallel_in,
    input  load_ready, serial_out, serial_valid, frame_start, frame_end, busy
  );

  modport slave (
    input  load_valid, parallel_in,
    output load_ready, serial_out, serial_valid, frame_start, frame_end, busy
  );
endinterface

// File: rtl/piso_shift_register.sv
// piso_shift_register
// Parallel-in serial-out transmitter. Accepts one word per handshake and
// streams it LSB first, one bit per clock, with frame_start/frame_end markers.
// Back-to-back words stream with no gap (next load accepted on frame_end).
// Build option: define PARITY_EN to append an even-parity bit to each frame.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      piso_shift_register_if.slave (load_valid/parallel_in/load_ready,
//            serial_out/serial_valid/frame_start/frame_end/busy)
//
// state  | meaning
// IDLE   | no frame, ready for a word
// SHIFT  | driving data bit cnt of the current word
// PARITY | driving the parity bit (PARITY_EN only)
module piso_shift_register #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  piso_shift_register_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH);

`ifdef PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [0:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sh;
  logic [CNT_W-1:0] cnt;
`ifdef PARITY_EN
  logic             par_q;
`endif

  logic load_ready, serial_out, serial_valid, frame_start, frame_end;
  logic accept, last_bit;

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));
  // load_ready depends on registered state only, so accept never feeds outputs
  assign accept   = bus.load_valid && load_ready;

  always_comb begin
    state_nxt    = state;
    load_ready   = 1'b0;
    serial_out   = 1'b0;
    serial_valid = 1'b0;
    frame_start  = 1'b0;
    frame_end    = 1'b0;
    case (state)
      IDLE: begin
        load_ready = 1'b1;
      end
      SHIFT: begin
        serial_out   = sh[0];
        serial_valid = 1'b1;
        frame_start  = (cnt == '0);
        if (last_bit) begin
`ifdef PARITY_EN
          state_nxt  = PARITY;
`else
          frame_end  = 1'b1;
          load_ready = 1'b1;
          state_nxt  = IDLE;
`endif
        end
      end
`ifdef PARITY_EN
      PARITY: begin
        serial_out   = par_q;
        serial_valid = 1'b1;
        frame_end    = 1'b1;
        load_ready   = 1'b1;
        state_nxt    = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
    if (accept) state_nxt = SHIFT;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      sh    <= '0;
      cnt   <= '0;
`ifdef PARITY_EN
      par_q <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (accept) begin
        sh    <= bus.parallel_in;
        cnt   <= '0;
`ifdef PARITY_EN
        par_q <= ^bus.parallel_in;
`endif
      end else if (state == SHIFT) begin
        sh  <= sh >> 1;
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign bus.load_ready   = load_ready;
  assign bus.serial_out   = serial_out;
  assign bus.serial_valid = serial_valid;
  assign bus.frame_start  = frame_start;
  assign bus.frame_end    = frame_end;
  assign bus.busy         = serial_valid;
endmodule

// File: tb/tb_piso_shift_register.sv
// tb_piso_shift_register
// Directed bench for piso_shift_register: a WIDTH=8 instance driven from a
// vector table plus hand-written reset and WIDTH=2 sequences.
module tb_piso_shift_register;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;

`ifdef PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  piso_shift_register_if #(.WIDTH(8)) ifs ();
  piso_shift_register_if #(.WIDTH(2)) ifs2 ();

  piso_shift_register #(.WIDTH(8)) dut (.clk(clk), .reset_n(reset_n), .bus(ifs.slave));
  piso_shift_register #(.WIDTH(2)) dut2 (.clk(clk), .reset_n(reset_n), .bus(ifs2.slave));

  always #5 clk = ~clk;

  typedef struct {
    logic       lv;
    logic [7:0] pin;
    logic       rdy;
    logic       out;
    logic       vld;
    logic       fs;
    logic       fe;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic add_row(input logic lv, input logic [7:0] pin, input logic rdy,
                         input logic out, input logic vld, input logic fs, input logic fe);
    vec_t v;
    v.lv = lv; v.pin = pin; v.rdy = rdy; v.out = out; v.vld = vld; v.fs = fs; v.fe = fe;
    vecs.push_back(v);
  endtask

  // One frame of word w; load inputs held at lv_mid/pin_mid^i during
  // non-final bits and lv_last/pin_last during the frame_end bit.
  task automatic add_frame(input logic [7:0] w, input logic lv_mid, input logic [7:0] pin_mid,
                           input logic lv_last, input logic [7:0] pin_last);
    for (int i = 0; i < 8; i++) begin
      logic last;
      last = (i == 7) && !PAR;
      add_row(last ? lv_last : lv_mid, last ? pin_last : (pin_mid ^ 8'(i)),
              last, w[i], 1'b1, i == 0, last);
    end
    if (PAR) add_row(lv_last, pin_last, 1'b1, ^w, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " ready"}, ifs.load_ready, 1'b1);
    chk({tag, " valid"}, ifs.serial_valid, 1'b0);
    chk({tag, " out"}, ifs.serial_out, 1'b0);
    chk({tag, " fs"}, ifs.frame_start, 1'b0);
    chk({tag, " fe"}, ifs.frame_end, 1'b0);
    chk({tag, " busy"}, ifs.busy, 1'b0);
  endtask

  initial begin
    logic [7:0] w01;
    ifs.load_valid = 1'b0;
    ifs.parallel_in = '0;
    ifs2.load_valid = 1'b0;
    ifs2.parallel_in = '0;

    // Reset state, then release just after an edge
    #3;
    chk_idle("reset");
    chk("reset2 ready", ifs2.load_ready, 1'b1);
    chk("reset2 valid", ifs2.serial_valid, 1'b0);
    tick();
    reset_n = 1'b1;

    // Vector table
    add_row(1'b0, 8'h00, 1, 0, 0, 0, 0);
    add_row(1'b1, 8'hA5, 1, 0, 0, 0, 0);
    add_frame(8'hA5, 1'b0, 8'h00, 1'b0, 8'h00);
    add_row(1'b1, 8'h3C, 1, 0, 0, 0, 0);
    add_frame(8'h3C, 1'b1, 8'hC3, 1'b1, 8'hC3);  // hold valid: C3 taken on frame_end
    add_frame(8'hC3, 1'b0, 8'h00, 1'b1, 8'h07);  // 07 taken on frame_end
    add_frame(8'h07, 1'b0, 8'h00, 1'b0, 8'h00);
    add_row(1'b1, 8'h81, 1, 0, 0, 0, 0);
    add_frame(8'h81, 1'b1, 8'h55, 1'b0, 8'h00);  // valid held with changing data
    add_row(1'b0, 8'h00, 1, 0, 0, 0, 0);
    add_row(1'b0, 8'h00, 1, 0, 0, 0, 0);

    foreach (vecs[r]) begin
      ifs.load_valid = vecs[r].lv;
      ifs.parallel_in = vecs[r].pin;
      #1;
      chk($sformatf("row%0d ready", r), ifs.load_ready, vecs[r].rdy);
      chk($sformatf("row%0d out", r), ifs.serial_out, vecs[r].out);
      chk($sformatf("row%0d valid", r), ifs.serial_valid, vecs[r].vld);
      chk($sformatf("row%0d fs", r), ifs.frame_start, vecs[r].fs);
      chk($sformatf("row%0d fe", r), ifs.frame_end, vecs[r].fe);
      chk($sformatf("row%0d busy", r), ifs.busy, vecs[r].vld);
      tick();
    end
    ifs.load_valid = 1'b0;

    // Reset mid-frame of FF
    ifs.load_valid = 1'b1;
    ifs.parallel_in = 8'hFF;
    tick();
    ifs.load_valid = 1'b0;
    ifs.parallel_in = 8'h00;
    tick(); tick(); tick();
    chk("midframe valid", ifs.serial_valid, 1'b1);
    chk("midframe out", ifs.serial_out, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_idle("async reset");
    tick();
    reset_n = 1'b1;
    chk_idle("post reset");

    // New frame 01 after reset
    w01 = 8'h01;
    ifs.load_valid = 1'b1;
    ifs.parallel_in = w01;
    tick();
    ifs.load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("w01 bit%0d out", i), ifs.serial_out, w01[i]);
      chk($sformatf("w01 bit%0d valid", i), ifs.serial_valid, 1'b1);
      chk($sformatf("w01 bit%0d fs", i), ifs.frame_start, i == 0);
      chk($sformatf("w01 bit%0d fe", i), ifs.frame_end, (i == 7) && !PAR);
      tick();
    end
    if (PAR) begin
      chk("w01 parity out", ifs.serial_out, 1'b1);
      chk("w01 parity fe", ifs.frame_end, 1'b1);
      tick();
    end
    chk_idle("w01 end");

    // WIDTH=2 corner: 2'b10 -> bits 0,1
    ifs2.load_valid = 1'b1;
    ifs2.parallel_in = 2'b10;
    tick();
    ifs2.load_valid = 1'b0;
    chk("w2 b0 out", ifs2.serial_out, 1'b0);
    chk("w2 b0 valid", ifs2.serial_valid, 1'b1);
    chk("w2 b0 fs", ifs2.frame_start, 1'b1);
    chk("w2 b0 fe", ifs2.frame_end, 1'b0);
    chk("w2 b0 ready", ifs2.load_ready, 1'b0);
    tick();
    chk("w2 b1 out", ifs2.serial_out, 1'b1);
    chk("w2 b1 valid", ifs2.serial_valid, 1'b1);
    chk("w2 b1 fs", ifs2.frame_start, 1'b0);
    chk("w2 b1 fe", ifs2.frame_end, !PAR);
    chk("w2 b1 ready", ifs2.load_ready, !PAR);
    tick();
    if (PAR) begin
      chk("w2 parity out", ifs2.serial_out, 1'b1);
      chk("w2 parity fe", ifs2.frame_end, 1'b1);
      tick();
    end
    chk("w2 end valid", ifs2.serial_valid, 1'b0);
    chk("w2 end ready", ifs2.load_ready, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/piso_shift_register.md
# piso_shift_register

Parallel-in serial-out transmitter that accepts one parallel word per handshake and drives it out one bit per clock, LSB first, with frame markers. It is the serializing end of the team's shift-register family and is the counterpart of the parallel register stage. It feeds a serial link or a serial-in receiver. Back-to-back words stream with no idle gap between frames.

## Interface
Parameters:
- WIDTH, 8, data word width in bits; legal range WIDTH >= 2.

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  rising-edge clock for all state.
- reset_n  input  1  asynchronous active-low reset.
- load_valid  input  1  producer has a word on parallel_in.
- parallel_in  input  WIDTH  word to serialize; sampled only on an accepted load.
- load_ready  output  1  block can accept a word this cycle.
- serial_out  output  1  current serial bit.
- serial_valid  output  1  serial_out carries a frame bit this cycle.
- frame_start  output  1  high during the first bit (bit 0) of a frame.
- frame_end  output  1  high during the last bit of a frame.
- busy  output  1  frame in progress (equals serial_valid).

## Operation
- State: shift register sh[WIDTH-1:0], bit counter cnt of width $clog2(WIDTH), FSM {IDLE, SHIFT, PARITY}. PARITY exists only with PARITY_EN.
- Load accepted at a rising edge when load_valid && load_ready: sh <= parallel_in, cnt <= 0, state <= SHIFT.
- IDLE: load_ready=1; serial_out=0, serial_valid=0, frame_start=0, frame_end=0, busy=0.
- SHIFT: serial_out=sh[0], serial_valid=1, frame_start=(cnt==0). Each edge: sh <= sh>>1, cnt <= cnt+1.
- Last data bit is cnt==WIDTH-1. Without PARITY_EN: frame_end=1, load_ready=1; next state is SHIFT (new word, cnt=0) if a load is accepted, else IDLE.
- With PARITY_EN: the last data bit goes to PARITY with frame_end=0, load_ready=0. PARITY: serial_out=parity bit, serial_valid=1, frame_end=1, load_ready=1; next state is SHIFT on an accepted load, else IDLE.
- load_ready=0 in every other SHIFT cycle. load_valid is ignored there; the producer holds it and parallel_in stable.
- All outputs are decoded from registered state only. There is no combinational path from load_valid or parallel_in to any output.
- Reset (any time, including mid-frame): state=IDLE, sh=0, cnt=0, parity register=0. All outputs are 0 except load_ready=1. A partial frame is discarded and no frame_end is issued.

## Timing
- Load accepted at edge k: bit 0 appears on serial_out in cycle k+1 with frame_start=1.
- Frame length is WIDTH cycles without parity, WIDTH+1 cycles with PARITY_EN.
- A load accepted in a frame_end cycle starts the next frame in the very next cycle. Sustained throughput is one bit per clock.
- Minimum spacing between accepted loads is the frame length.
- Reset assertion takes effect immediately (asynchronous). Deassertion is synchronous in effect: the first load can be accepted at the first rising edge after reset_n goes high.

## Configuration
- PARITY_EN defined: an even-parity bit (XOR of all WIDTH data bits) is captured into a register at load. It is sent as one extra serial bit after bit WIDTH-1, with frame_end on that bit.
- PARITY_EN undefined: there is no PARITY state and no parity register. Frames are exactly WIDTH bits and frame_end is on bit WIDTH-1.

## Test plan
- WIDTH=8, no parity, load 8'hA5 from IDLE -> serial_out 1,0,1,0,0,1,0,1 over cycles k+1..k+8. frame_start only at k+1, frame_end only at k+8. Return to IDLE, load_ready=1 at k+9.
- Back-to-back: load 8'h3C, then hold load_valid high with 8'hC3 -> 8'hC3 accepted in the frame_end cycle of 8'h3C. 16 contiguous valid bits: 0,0,1,1,1,1,0,0,1,1,0,0,0,0,1,1. No gap, and a second frame_start at bit 9.
- Flow control: hold load_valid=1 with changing parallel_in mid-frame -> load_ready=0 on non-final bits and no extra load. The frame is unchanged.
- Reset mid-frame: assert reset_n=0 after bit 3 of 8'hFF -> serial_valid, serial_out, frame_end drop to 0 immediately. load_ready=1. After release, a new load 8'h01 streams 1,0,0,0,0,0,0,0.
- PARITY_EN, load 8'h07 -> 9 bits 1,1,1,0,0,0,0,0,1. frame_end on the 9th bit. Then load 8'hA5 -> 9th bit 0.
- WIDTH=2 corner: load 2'b10 -> bits 0,1. frame_start and frame_end each one cycle, on consecutive cycles.
